instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_pkg.sv | 27 ++
 rtl/instr_mem_loader_byte_packer.sv | 37 +++
 rtl/instr_mem_loader.sv | 142 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader and the instruction memory.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CHECK state.
package instr_mem_loader_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MEM_DEPTH = 32;
  localparam int unsigned LEN_W     = 6;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CNT_W     = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    CHECK  = 3'd3,
`endif
    FINISH = 3'd4
  } state_t;

  // Requested word count limited to the memory depth
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned depth);
    return (32'(len) > depth) ? LEN_W'(depth) : len;
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Big-endian byte-to-word assembler: holds the first three bytes of a word and
// presents the complete word combinationally while the fourth byte is shifted in.
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              last_c
);

  localparam int unsigned HOLD_W = WORD_W - BYTE_W;

  logic [HOLD_W-1:0] hold_q;
  logic [CNT_W-1:0]  cnt_q;

  assign word_c = {hold_q, byte_in};
  assign last_c = shift && (cnt_q == CNT_W'(3));

  // Shift accepted bytes in MSB-first; clear discards a partial word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else if (shift) begin
      hold_q <= {hold_q[HOLD_W-BYTE_W-1:0], byte_in};
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Serial-byte instruction memory loader: assembles big-endian words and writes
// them to consecutive addresses. Macro LOADER_CHECKSUM_EN enables the XOR
// trailer check; without it checksumError is tied low.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  input  logic [BYTE_W-1:0] byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [WORD_W-1:0] writeData,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              checksumError
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_LAST = CHECK;
`else
  localparam state_t AFTER_LAST = FINISH;
`endif

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic              byte_ready_d, write_enable_d, busy_d, done_d;
  logic              accept_c, pk_clear_c, pk_last_c, word_last_c, start_ok_c;
  logic [WORD_W-1:0] pk_word_c;

  assign accept_c    = byteValid && byteReady && !abort;
  assign pk_clear_c  = abort || (state_q == IDLE);
  assign start_ok_c  = (state_q == IDLE) && start && !abort;
  assign word_last_c = (writeAddress + ADDR_W'(1)) == ADDR_W'(len_q);

  instr_mem_loader_byte_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (pk_clear_c),
    .shift   (accept_c),
    .byte_in (byteIn),
    .word_c  (pk_word_c),
    .last_c  (pk_last_c)
  );

  // State register plus registered Moore flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byteReady   <= 1'b0;
      writeEnable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      byteReady   <= byte_ready_d;
      writeEnable <= write_enable_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Next-state: abort wins over start and byte transfers
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (start) state_d = (length == '0) ? FINISH : LOAD;
        LOAD:   if (pk_last_c) state_d = WRITE;
        WRITE:  state_d = word_last_c ? AFTER_LAST : LOAD;
`ifdef LOADER_CHECKSUM_EN
        CHECK:  if (pk_last_c) state_d = FINISH;
`endif
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Flags for the upcoming state, registered alongside it
  always_comb begin
    byte_ready_d   = 1'b0;
    write_enable_d = 1'b0;
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == FINISH);
`ifdef LOADER_CHECKSUM_EN
    byte_ready_d   = (state_d == LOAD) || (state_d == CHECK);
`else
    byte_ready_d   = (state_d == LOAD);
`endif
    write_enable_d = (state_d == WRITE);
  end

  // Session length, address counter, write word and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      writeAddress <= '0;
      writeData    <= '0;
      overflow     <= 1'b0;
    end else begin
      if (start_ok_c) begin
        len_q        <= clamp_len(length, DEPTH);
        writeAddress <= '0;
        overflow     <= (32'(length) > DEPTH);
      end
      if ((state_q == LOAD) && pk_last_c) writeData <= pk_word_c;
      if ((state_q == WRITE) && !word_last_c) writeAddress <= writeAddress + ADDR_W'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] xor_acc_q;

  // Running XOR of written words, compared against the trailer word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_acc_q     <= '0;
      checksumError <= 1'b0;
    end else if (start_ok_c) begin
      xor_acc_q     <= '0;
      checksumError <= 1'b0;
    end else begin
      if (state_q == WRITE) xor_acc_q <= xor_acc_q ^ writeData;
      if ((state_q == CHECK) && pk_last_c) checksumError <= (pk_word_c != xor_acc_q);
    end
  end
`else
  assign checksumError = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a session model predicts writes and
// done flags, a negedge monitor pops and compares. Honours LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 32;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic ovf; logic cerr; logic gap_chk; } done_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [5:0]        length = '0;
  logic              abort = 1'b0;
  logic [7:0]        byteIn = '0;
  logic              byteValid = 1'b0;
  logic              byteReady, writeEnable, busy, done, overflow, checksumError;
  logic [ADDR_W-1:0] writeAddress;
  logic [31:0]       writeData;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_we_cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;

  wr_t         exp_w[$];
  done_t       exp_d[$];
  logic [7:0]  tx[$];
  logic [31:0] pre_words[$];

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .length       (length),
    .abort        (abort),
    .byteIn       (byteIn),
    .byteValid    (byteValid),
    .byteReady    (byteReady),
    .writeEnable  (writeEnable),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .checksumError(checksumError)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and done pulse is matched against the scoreboard
  always @(negedge clk) begin : monitor
    wr_t   e;
    done_t d;
    if (rst_n) begin
      if (writeEnable) begin
        last_we_cyc = cyc;
        chk("addr_below_depth", 32'(writeAddress < DEPTH), 32'd1);
        if (exp_w.size() == 0) begin
          chk("unexpected_write", 32'(writeEnable), 32'd0);
        end else begin
          e = exp_w.pop_front();
          chk("write_addr", writeAddress, e.addr);
          chk("write_data", writeData, e.data);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_d.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          d = exp_d.pop_front();
          chk("overflow", 32'(overflow), 32'(d.ovf));
          chk("checksumError", 32'(checksumError), 32'(d.cerr));
          chk("busy_at_done", 32'(busy), 32'd1);
          chk("writes_missing_at_done", 32'(exp_w.size()), 32'd0);
          if (d.gap_chk) chk("done_after_last_write", 32'(cyc - last_we_cyc), 32'd1);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byteReady"}, 32'(byteReady), 32'd0);
    chk({tag, "_writeEnable"}, 32'(writeEnable), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_checksumError"}, 32'(checksumError), 32'd0);
    chk({tag, "_writeAddress"}, writeAddress, 32'd0);
    chk({tag, "_writeData"}, writeData, 32'd0);
  endtask

  task automatic pulse_start(input int len);
    @(negedge clk);
    start = 1'b1;
    length = 6'(len);
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feed the tx queue; mode 0 = always valid, 1 = toggling, 2 = random
  task automatic send_bytes(input int mode, input bit swb);
    int i, guard;
    bit tog, v, sb;
    i = 0; guard = 0; tog = 1'b1; sb = 1'b0;
    while (i < tx.size() && guard < 4000) begin
      @(negedge clk);
      start = 1'b0;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      if (swb && !sb && i == 2) begin
        start = 1'b1;
        length = 6'd5;
        sb = 1'b1;
      end
      byteValid = v;
      byteIn = v ? tx[i] : 8'($urandom);
      if (v && byteReady) i++;
      guard++;
    end
    chk("bytes_accepted", 32'(i), 32'(tx.size()));
    @(negedge clk);
    byteValid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(done_cnt != d0), 32'd1);
  endtask

  // Bytes offered while idle must be ignored
  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_byteReady", 32'(byteReady), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      byteValid = 1'b1;
      byteIn = 8'($urandom);
    end
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  // Reference session: min(len, DEPTH) words at addresses 0.., optional trailer
  task automatic run_session(input int len, input int mode, input bit bad, input bit swb);
    int n, d0;
    logic [31:0] w, x;
    done_t d;
    n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    x = '0;
    tx.delete();
    for (int i = 0; i < n; i++) begin
      if (pre_words.size() > 0) w = pre_words.pop_front();
      else w = $urandom;
      exp_w.push_back(wr_t'{32'(i), w});
      x ^= w;
      for (int b = 3; b >= 0; b--) tx.push_back(w[8*b +: 8]);
    end
    d.ovf = (len > int'(DEPTH));
    d.cerr = 1'b0;
    d.gap_chk = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    if (n > 0) begin
      w = bad ? x + 32'd1 : x;
      for (int b = 3; b >= 0; b--) tx.push_back(w[8*b +: 8]);
      d.cerr = bad;
    end
`else
    d.gap_chk = (n > 0);
`endif
    exp_d.push_back(d);
    d0 = done_cnt;
    pulse_start(len);
    send_bytes(mode, swb);
    wait_done(d0);
    if (n == 0) chk("len0_done_latency_le2", 32'((done_cyc - start_cyc) <= 2), 32'd1);
`ifndef LOADER_CHECKSUM_EN
    if (bad) idle_noise(4);
`endif
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] w0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Two words from a counting byte stream
    pre_words.push_back(32'h01020304);
    pre_words.push_back(32'h05060708);
    run_session(2, 0, 1'b0, 1'b0);

    // Zero-length session, then bytes offered while idle
    run_session(0, 0, 1'b1, 1'b0);

    // byteValid toggling every cycle
    pre_words.push_back(32'hDEADBEEF);
    run_session(1, 1, 1'b0, 1'b0);

    // Length beyond memory depth, then exactly at depth with a start while busy
    run_session(40, 2, 1'b0, 1'b0);
    run_session(32, 0, 1'b0, 1'b1);

    // Abort two bytes into the second word, with a byte offered on the abort cycle
    tx.delete();
    w0 = $urandom;
    exp_w.push_back(wr_t'{32'd0, w0});
    for (int b = 3; b >= 0; b--) tx.push_back(w0[8*b +: 8]);
    tx.push_back(8'($urandom));
    tx.push_back(8'($urandom));
    pulse_start(3);
    send_bytes(0, 1'b0);
    abort = 1'b1;
    byteValid = 1'b1;
    byteIn = 8'($urandom);
    @(negedge clk);
    abort = 1'b0;
    byteValid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_byteReady", 32'(byteReady), 32'd0);
    chk("abort_writeEnable", 32'(writeEnable), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    run_session(2, 2, 1'b0, 1'b0);

    // Randomised sessions
    for (int r = 0; r < 6; r++) begin
      run_session(int'($urandom_range(1, 9)), 2, 1'($urandom_range(0, 1)), 1'(r % 2));
    end

`ifdef LOADER_CHECKSUM_EN
    pre_words.push_back(32'h11111111);
    pre_words.push_back(32'h22222222);
    run_session(2, 0, 1'b0, 1'b0);
    pre_words.push_back(32'h11111111);
    pre_words.push_back(32'h22222222);
    run_session(2, 0, 1'b1, 1'b0);
`endif

    // Reset in the middle of a session
    tx.delete();
    w0 = $urandom | 32'h1;
    exp_w.push_back(wr_t'{32'd0, w0});
    for (int b = 3; b >= 0; b--) tx.push_back(w0[8*b +: 8]);
    tx.push_back(8'($urandom));
    tx.push_back(8'($urandom));
    pulse_start(4);
    send_bytes(0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    chk("midreset_first_word_written", 32'(exp_w.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_noise(6);

    run_session(3, 1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("final_pending_writes", 32'(exp_w.size()), 32'd0);
    chk("final_pending_done", 32'(exp_d.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
